// File: rtl/keypad_scan_4x4_pkg.sv
// rtl/keypad_scan_4x4_pkg.sv - shared widths and enums for the 4x4 keypad scanner
package keypad_scan_4x4_pkg;

    localparam int KEY_CODE_W = 4;
    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 4;

    // Result of classifying one full 16-sample frame
    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_KEY,
        CLS_MULTI
    } cls_t;

    // Committed key state
    typedef enum logic {
        ST_IDLE,
        ST_HELD
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with configurable width and reset value
// Ports:
//   clk   in         destination clock
//   rst_n in         asynchronous active-low reset, loads RESET_VAL into both flops
//   d     in  WIDTH  asynchronous input
//   q     out WIDTH  synchronised output
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_4x4.sv
// rtl/keypad_scan_4x4.sv - 4x4 matrix keypad scanner with frame debounce and press/release pulses
// Ports:
//   clk         in     system clock
//   rst_n       in     asynchronous active-low reset
//   col_in      in  4  keypad columns, active-low, asynchronous
//   row_out     out 4  keypad rows, one-cold drive
//   key_code    out 4  {row, col} of the committed key
//   key_valid   out 1  high while a committed key is held
//   key_press   out 1  one-clk pulse on a committed press
//   key_release out 1  one-clk pulse on a committed release
module keypad_scan_4x4
    import keypad_scan_4x4_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_COLS-1:0]   col_in,
    output logic [NUM_ROWS-1:0]   row_out,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_press,
    output logic                  key_release
);

    localparam int CNT_W   = $clog2(SCAN_DIV);
    localparam int MATCH_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int NSAMP   = NUM_ROWS * NUM_COLS;

    logic [NUM_COLS-1:0] col_sync;

    sync_2ff #(
        .WIDTH     (NUM_COLS),
        .RESET_VAL ({NUM_COLS{1'b1}})
    ) u_col_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (col_in),
        .q     (col_sync)
    );

    // ---------------- scanner ----------------
    logic [CNT_W-1:0] slot_cnt;
    logic [1:0]       row_idx;
    logic [NSAMP-1:0] samples;
    logic             frame_done;
    logic             tick;

    assign tick    = (slot_cnt == CNT_W'(SCAN_DIV - 1));
    assign row_out = ~(NUM_ROWS'(1) << row_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt   <= '0;
            row_idx    <= '0;
            samples    <= '1;
            frame_done <= 1'b0;
        end else begin
            slot_cnt   <= tick ? '0 : slot_cnt + 1'b1;
            frame_done <= tick && (row_idx == 2'd3);
            if (tick) begin
                samples[{row_idx, 2'b00} +: NUM_COLS] <= col_sync;
                row_idx                               <= row_idx + 1'b1;
            end
        end
    end

    // ---------------- classifier ----------------
    // Sample index is row*4+col, so the index of a lone low bit is the key code.
    logic [4:0]            low_cnt;
    logic [KEY_CODE_W-1:0] low_idx;
    cls_t                  frame_cls;

    always_comb begin
        low_cnt = '0;
        low_idx = '0;
        for (int i = 0; i < NSAMP; i++) begin
            if (!samples[i]) begin
                low_cnt = low_cnt + 5'd1;
                low_idx = KEY_CODE_W'(i);
            end
        end
        if (low_cnt == 5'd0)      frame_cls = CLS_NONE;
        else if (low_cnt == 5'd1) frame_cls = CLS_KEY;
        else                      frame_cls = CLS_MULTI;
    end

    // ---------------- debounce ----------------
    cls_t                  cand_cls;
    logic [KEY_CODE_W-1:0] cand_code;
    logic [MATCH_W-1:0]    match_cnt;
    logic                  run_done;

    assign run_done = (match_cnt == MATCH_W'(DEBOUNCE_FRAMES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_cls  <= CLS_NONE;
            cand_code <= '0;
            match_cnt <= '0;
        end else if (frame_done) begin
            if (frame_cls == cand_cls && (frame_cls != CLS_KEY || low_idx == cand_code)) begin
                if (!run_done) match_cnt <= match_cnt + 1'b1;
            end else begin
                cand_cls  <= frame_cls;
                cand_code <= low_idx;
                match_cnt <= MATCH_W'(1);
            end
        end
    end

    // ---------------- committed-state FSM ----------------
    state_t                state, next_state;
    logic [KEY_CODE_W-1:0] held_code, next_held_code;
    logic                  swap_pending;
    logic                  commit_key, commit_none;
    logic                  press_d, release_d, swap_d;
    logic [KEY_CODE_W-1:0] code_d;

    // Commits fire for a single cycle: the committed state matches the candidate afterwards.
    assign commit_key  = run_done && cand_cls == CLS_KEY
                         && (state == ST_IDLE || cand_code != held_code);
    assign commit_none = run_done && cand_cls == CLS_NONE && state == ST_HELD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            held_code    <= '0;
            swap_pending <= 1'b0;
            key_code     <= '0;
            key_valid    <= 1'b0;
            key_press    <= 1'b0;
            key_release  <= 1'b0;
        end else begin
            state        <= next_state;
            held_code    <= next_held_code;
            swap_pending <= swap_d;
            key_code     <= code_d;
            key_valid    <= (next_state == ST_HELD);
            key_press    <= press_d;
            key_release  <= release_d;
        end
    end

    always_comb begin
        next_state     = state;
        next_held_code = held_code;
        if (commit_key) begin
            next_state     = ST_HELD;
            next_held_code = cand_code;
        end else if (commit_none) begin
            next_state = ST_IDLE;
        end
    end

    // A key-to-key change releases the old code first and presses the new one a cycle later.
    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        swap_d    = 1'b0;
        code_d    = key_code;
        if (swap_pending) begin
            press_d = 1'b1;
            code_d  = held_code;
        end else if (commit_key) begin
            if (state == ST_HELD) begin
                release_d = 1'b1;
                swap_d    = 1'b1;
            end else begin
                press_d = 1'b1;
                code_d  = cand_code;
            end
        end else if (commit_none) begin
            release_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// tb/tb_keypad_scan_4x4.sv - self-checking bench for keypad_scan_4x4
module tb_keypad_scan_4x4;

    localparam int SD = 4;
    localparam int DF = 3;
    localparam int FR = 4 * SD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] col_in, row_out, key_code;
    logic       key_valid, key_press, key_release;
    logic [15:0] mask = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_scan_4x4 #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .col_in      (col_in),
        .row_out     (row_out),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_press   (key_press),
        .key_release (key_release)
    );

    // Physical keypad: a pressed key shorts its row to its column.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_out[r] && mask[r*4+c]) col_in[c] = 1'b0;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         e = 0;
    int         prs_e = -1, rel_e = -1, prs_code = 0;
    bit         rel_drop = 0;
    bit         m_held = 0;
    int         m_held_code = 0;
    logic [3:0] m_code = '0;
    bit         m_valid = 0, m_press = 0, m_release = 0;
    int         hist[$];

    task automatic model_frame();
        int n, c, sig;
        bit all_eq;
        n = $countones(mask);
        c = 0;
        for (int i = 0; i < 16; i++) if (mask[i]) c = i;
        sig = (n == 0) ? 0 : (n == 1) ? 16 + c : 100;
        hist.push_back(sig);
        if (hist.size() > DF) void'(hist.pop_front());
        all_eq = (hist.size() == DF);
        foreach (hist[i]) if (hist[i] != sig) all_eq = 0;
        if (all_eq && sig != 100) begin
            if (sig == 0 && m_held) begin
                rel_e = e + 2; rel_drop = 1; m_held = 0;
            end else if (sig >= 16 && !m_held) begin
                prs_e = e + 2; prs_code = sig - 16; m_held = 1; m_held_code = sig - 16;
            end else if (sig >= 16 && m_held && sig - 16 != m_held_code) begin
                rel_e = e + 2; rel_drop = 0; prs_e = e + 3;
                prs_code = sig - 16; m_held_code = sig - 16;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            e = 0; prs_e = -1; rel_e = -1; m_held = 0; m_held_code = 0;
            m_code = '0; m_valid = 0; m_press = 0; m_release = 0;
            hist.delete();
        end else begin
            e++;
            m_press = 0; m_release = 0;
            if (e == rel_e) begin m_release = 1; if (rel_drop) m_valid = 0; end
            if (e == prs_e) begin m_press = 1; m_valid = 1; m_code = 4'(prs_code); end
            if (e % FR == 0) model_frame();
        end
    end

    // ---------------- compare + observation ----------------
    int press_count = 0, rel_count = 0, valid_low = 0;
    int last_press_e = -1, last_press_code = -1, last_rel_e = -1, last_rel_code = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_row_out", row_out, 4'b1110);
            chk("reset_key_code", key_code, 0);
            chk("reset_key_valid", key_valid, 0);
            chk("reset_key_press", key_press, 0);
            chk("reset_key_release", key_release, 0);
        end else begin
            logic [3:0] exp_row;
            exp_row = ~(4'b0001 << ((e / SD) % 4));
            chk("row_out", row_out, exp_row);
            chk("key_code", key_code, m_code);
            chk("key_valid", key_valid, m_valid);
            chk("key_press", key_press, m_press);
            chk("key_release", key_release, m_release);
            if (key_press) begin press_count++; last_press_e = e; last_press_code = key_code; end
            if (key_release) begin rel_count++; last_rel_e = e; last_rel_code = key_code; end
            if (!key_valid) valid_low++;
        end
    end

    task automatic clr_obs();
        press_count = 0; rel_count = 0; valid_low = 0;
    endtask

    task automatic frame(input logic [15:0] m);
        mask = m;
        repeat (FR) @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        mask  = '0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // 1: idle frames 1-10
        repeat (10) frame(16'h0000);
        chk("s1_press_count", press_count, 0);
        chk("s1_release_count", rel_count, 0);

        // 2: key 9 held frames 11-15, commit at frame 13 end (edge 208) + 2
        clr_obs();
        repeat (5) frame(16'h0200);
        chk("s2_press_count", press_count, 1);
        chk("s2_press_edge", last_press_e, 210);
        chk("s2_press_code", last_press_code, 9);

        // 3: released frames 16-19, commit at frame 18 end
        clr_obs();
        repeat (4) frame(16'h0000);
        chk("s3_release_count", rel_count, 1);
        chk("s3_release_edge", last_rel_e, 290);
        chk("s3_release_code", last_rel_code, 9);
        chk("s3_code_kept", key_code, 9);

        // 4: bounce frames 20-25, stable key 5 frames 26-29
        clr_obs();
        for (int i = 0; i < 6; i++) frame((i % 2 == 0) ? 16'h0020 : 16'h0000);
        chk("s4_bounce_pulses", press_count + rel_count, 0);
        repeat (4) frame(16'h0020);
        chk("s4_press_count", press_count, 1);
        chk("s4_press_edge", last_press_e, 450);
        chk("s4_press_code", last_press_code, 5);

        // 5: 5 -> 0 (frames 30-33) -> 3 (frames 34-37), then keys 0+3 together
        clr_obs();
        repeat (4) frame(16'h0001);
        repeat (4) frame(16'h0008);
        chk("s5_valid_low_cycles", valid_low, 0);
        chk("s5_press_count", press_count, 2);
        chk("s5_release_count", rel_count, 2);
        chk("s5_last_release_edge", last_rel_e, 578);
        chk("s5_last_release_code", last_rel_code, 0);
        chk("s5_last_press_edge", last_press_e, 579);
        chk("s5_last_press_code", last_press_code, 3);
        clr_obs();
        repeat (4) frame(16'h0009);
        frame(16'h0008);
        chk("s5_multi_pulses", press_count + rel_count, 0);
        chk("s5_multi_code", key_code, 3);
        chk("s5_multi_valid", key_valid, 1);

        // 6: reset mid-HELD with key 3 still down
        mask = 16'h0008;
        repeat (8) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("s6_async_valid", key_valid, 0);
        chk("s6_async_code", key_code, 0);
        chk("s6_async_row", row_out, 4'b1110);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        clr_obs();
        repeat (4) frame(16'h0008);
        chk("s6_press_count", press_count, 1);
        chk("s6_press_edge", last_press_e, 50);
        chk("s6_press_code", last_press_code, 3);

        // random runs of none / single / double keys
        begin
            logic [15:0] m;
            int          r, a, b;
            m = 16'h0000;
            for (int f = 0; f < 40; f++) begin
                r = $urandom_range(0, 9);
                if (r >= 4 && r <= 5) m = 16'h0000;
                else if (r >= 6 && r <= 8) m = 16'h0001 << $urandom_range(0, 15);
                else if (r == 9) begin
                    a = $urandom_range(0, 15);
                    b = (a + $urandom_range(1, 15)) % 16;
                    m = (16'h0001 << a) | (16'h0001 << b);
                end
                frame(m);
            end
        end
        frame(16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
